// File: rtl/ps2_kbd_rx_fifo.sv
// PS/2 keyboard receiver: synchronises ps2_clk/ps2_data, checks 11-bit frames, optionally folds E0/F0 prefixes, buffers entries in a FIFO.
// Latency: an entry reaches the FIFO head 2 clk cycles after the edge that captured the stop bit (plus SYNC_STAGES of pin synchronisation).
// Backpressure: none toward the keyboard; a push into a full FIFO is dropped and sets the sticky overflow flag.
//
// Ports:
//   clk        system clock, all logic on posedge
//   clrn       asynchronous active-low reset
//   ps2_clk    PS/2 clock pin (asynchronous)
//   ps2_data   PS/2 data pin (asynchronous)
//   nextdata_n active-low pop request, acted on at its 1->0 edge
//   data       scancode of the head entry
//   is_ext     E0 flag of the head entry
//   is_break   F0 flag of the head entry
//   ready      FIFO non-empty
//   overflow   sticky: an entry was dropped on a full FIFO; cleared by the next pop
//   frame_err  one-cycle pulse per discarded frame
//   count      number of entries held
//
// Optional feature macro: PS2_TIMEOUT_EN enables a mid-frame idle watchdog.

module ps2_kbd_rx_fifo #(
  parameter int FIFO_DEPTH     = 8,
  parameter int SYNC_STAGES    = 3,
  parameter int DECODE         = 1,
  parameter int TIMEOUT_CYCLES = 5000
) (
  input  logic                          clk,
  input  logic                          clrn,
  input  logic                          ps2_clk,
  input  logic                          ps2_data,
  input  logic                          nextdata_n,
  output logic [7:0]                    data,
  output logic                          is_ext,
  output logic                          is_break,
  output logic                          ready,
  output logic                          overflow,
  output logic                          frame_err,
  output logic [$clog2(FIFO_DEPTH):0]   count
);

  localparam int AW = $clog2(FIFO_DEPTH);

  // Elaboration-time parameter sanity checks.
  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("ps2_kbd_rx_fifo: FIFO_DEPTH must be a power of 2 and at least 2");
  end
  if (SYNC_STAGES < 2) begin : g_bad_sync
    $error("ps2_kbd_rx_fifo: SYNC_STAGES must be at least 2");
  end
  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("ps2_kbd_rx_fifo: TIMEOUT_CYCLES must be at least 1");
  end

  // ---------------------------------------------------------------------------
  // Pin synchronisers and falling-edge detect on ps2_clk
  // ---------------------------------------------------------------------------
  logic [SYNC_STAGES-1:0] clk_sync;
  logic [SYNC_STAGES-1:0] dat_sync;
  logic                   ps2_clk_s;
  logic                   ps2_dat_s;
  logic                   ps2_clk_d;
  logic                   ps2_fall;

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      clk_sync  <= '0;
      dat_sync  <= '0;
      ps2_clk_d <= 1'b0;
    end else begin
      clk_sync  <= {clk_sync[SYNC_STAGES-2:0], ps2_clk};
      dat_sync  <= {dat_sync[SYNC_STAGES-2:0], ps2_data};
      ps2_clk_d <= ps2_clk_s;
    end
  end

  assign ps2_clk_s = clk_sync[SYNC_STAGES-1];
  assign ps2_dat_s = dat_sync[SYNC_STAGES-1];
  // Sync chain and edge register reset low, so the idle-high line after
  // reset only produces a rising transition and never a spurious bit.
  assign ps2_fall  = ps2_clk_d & ~ps2_clk_s;

  // ---------------------------------------------------------------------------
  // Bit capture
  // ---------------------------------------------------------------------------
  logic [3:0]  bit_cnt;
  logic [10:0] frame_sr;
  logic        frame_rdy;
  logic        timeout_hit;

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      bit_cnt   <= 4'd0;
      frame_sr  <= '0;
      frame_rdy <= 1'b0;
    end else begin
      frame_rdy <= 1'b0;
      if (ps2_fall) begin
        frame_sr[bit_cnt] <= ps2_dat_s;
        if (bit_cnt == 4'd10) begin
          bit_cnt   <= 4'd0;
          frame_rdy <= 1'b1;
        end else begin
          bit_cnt <= bit_cnt + 4'd1;
        end
      end else if (timeout_hit) begin
        bit_cnt <= 4'd0;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Mid-frame idle watchdog
  // ---------------------------------------------------------------------------
`ifdef PS2_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] to_cnt;

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      to_cnt <= '0;
    end else if (ps2_fall || bit_cnt == 4'd0 || timeout_hit) begin
      to_cnt <= '0;
    end else begin
      to_cnt <= to_cnt + 1'b1;
    end
  end

  assign timeout_hit = (bit_cnt != 4'd0) && !ps2_fall && (to_cnt == TW'(TIMEOUT_CYCLES));
`else
  assign timeout_hit = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // Frame check and prefix folding
  // ---------------------------------------------------------------------------
  logic [7:0] rx_byte;
  logic       frame_ok;
  logic       ext_pend;
  logic       brk_pend;
  logic       push_vld;
  logic [9:0] push_dat;

  assign rx_byte  = frame_sr[8:1];
  // Odd parity: data plus parity bit must hold an odd number of ones.
  assign frame_ok = ~frame_sr[0] & (^frame_sr[9:1]) & frame_sr[10];

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      ext_pend  <= 1'b0;
      brk_pend  <= 1'b0;
      push_vld  <= 1'b0;
      push_dat  <= '0;
      frame_err <= 1'b0;
    end else begin
      push_vld  <= 1'b0;
      // A watchdog abort keeps pending prefixes; a bad frame clears them.
      frame_err <= timeout_hit;
      if (frame_rdy) begin
        if (!frame_ok) begin
          frame_err <= 1'b1;
          ext_pend  <= 1'b0;
          brk_pend  <= 1'b0;
        end else if (DECODE != 0 && rx_byte == 8'hE0) begin
          ext_pend <= 1'b1;
        end else if (DECODE != 0 && rx_byte == 8'hF0) begin
          brk_pend <= 1'b1;
        end else begin
          // In raw mode the pending flags never set, so flags push as 0.
          push_vld <= 1'b1;
          push_dat <= {ext_pend, brk_pend, rx_byte};
          ext_pend <= 1'b0;
          brk_pend <= 1'b0;
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // FIFO: entry = {is_ext, is_break, data}
  // ---------------------------------------------------------------------------
  logic [9:0]  ram [FIFO_DEPTH];
  logic [AW:0] wptr;
  logic [AW:0] rptr;
  logic        nd_d;
  logic        empty;
  logic        full;
  logic        pop;
  logic        push_ok;

  assign empty   = (wptr == rptr);
  assign full    = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
  assign pop     = nd_d & ~nextdata_n & ~empty;
  // A pop in the same cycle frees the slot, so a push into a full FIFO
  // is still accepted then.
  assign push_ok = push_vld & (~full | pop);

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      wptr     <= '0;
      rptr     <= '0;
      nd_d     <= 1'b1;
      overflow <= 1'b0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        ram[i] <= '0;
      end
    end else begin
      nd_d <= nextdata_n;
      if (push_ok) begin
        ram[wptr[AW-1:0]] <= push_dat;
        wptr              <= wptr + 1'b1;
      end
      if (pop) begin
        rptr <= rptr + 1'b1;
      end
      // Set has priority over the pop-driven clear.
      if (push_vld && !push_ok) begin
        overflow <= 1'b1;
      end else if (pop) begin
        overflow <= 1'b0;
      end
    end
  end

  // Head is read straight from the RAM; when empty this shows the last
  // entry read (or the cleared reset content).
  assign {is_ext, is_break, data} = ram[rptr[AW-1:0]];
  assign ready = ~empty;
  assign count = wptr - rptr;

endmodule

// File: tb/tb_ps2_kbd_rx_fifo.sv
module tb_ps2_kbd_rx_fifo;

  localparam int DEPTH = 4;
  localparam int TO    = 200;

  logic clk = 1'b0;
  logic clrn = 1'b0;
  logic ps2_clk = 1'b1;
  logic ps2_data = 1'b1;
  logic nextdata_n = 1'b1;

  logic [7:0] data_d, data_r;
  logic       ext_d, ext_r, brk_d, brk_r, rdy_d, rdy_r, ovf_d, ovf_r, fe_d, fe_r;
  logic [2:0] cnt_d, cnt_r;

  always #5 clk = ~clk;

  ps2_kbd_rx_fifo #(.FIFO_DEPTH(DEPTH), .SYNC_STAGES(3), .DECODE(1), .TIMEOUT_CYCLES(TO)) u_dec (
    .clk(clk), .clrn(clrn), .ps2_clk(ps2_clk), .ps2_data(ps2_data), .nextdata_n(nextdata_n),
    .data(data_d), .is_ext(ext_d), .is_break(brk_d), .ready(rdy_d), .overflow(ovf_d),
    .frame_err(fe_d), .count(cnt_d));

  ps2_kbd_rx_fifo #(.FIFO_DEPTH(DEPTH), .SYNC_STAGES(3), .DECODE(0), .TIMEOUT_CYCLES(TO)) u_raw (
    .clk(clk), .clrn(clrn), .ps2_clk(ps2_clk), .ps2_data(ps2_data), .nextdata_n(nextdata_n),
    .data(data_r), .is_ext(ext_r), .is_break(brk_r), .ready(rdy_r), .overflow(ovf_r),
    .frame_err(fe_r), .count(cnt_r));

  int n_chk = 0;
  int n_fail = 0;

  // Reference model state
  logic [9:0] q_d[$];
  logic [9:0] q_r[$];
  logic       m_ovf_d = 1'b0, m_ovf_r = 1'b0;
  logic       ext_p = 1'b0, brk_p = 1'b0;
  int         exp_err_d = 0, exp_err_r = 0;

  // Observed frame_err high cycles (a 1-cycle pulse counts once)
  int obs_err_d = 0, obs_err_r = 0;
  always @(negedge clk) begin
    if (fe_d === 1'b1) obs_err_d++;
    if (fe_r === 1'b1) obs_err_r++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  function automatic logic [10:0] mk_frame(input logic [7:0] b, input bit bad_start,
                                           input bit bad_par, input bit bad_stop);
    logic par;
    par = (~^b) ^ bad_par;
    return {~bad_stop, par, b, bad_start};
  endfunction

  task automatic send_bits(input logic [10:0] f, input int nbits);
    for (int i = 0; i < nbits; i++) begin
      ps2_data = f[i];
      wait_clk(4);
      ps2_clk = 1'b0;
      wait_clk(8);
      ps2_clk = 1'b1;
      wait_clk(4);
    end
    ps2_data = 1'b1;
  endtask

  task automatic model_frame(input logic [7:0] b, input bit ok);
    if (!ok) begin
      exp_err_d++;
      exp_err_r++;
      ext_p = 1'b0;
      brk_p = 1'b0;
    end else begin
      if (q_r.size() < DEPTH) q_r.push_back({2'b00, b});
      else m_ovf_r = 1'b1;
      if (b == 8'hE0) ext_p = 1'b1;
      else if (b == 8'hF0) brk_p = 1'b1;
      else begin
        if (q_d.size() < DEPTH) q_d.push_back({ext_p, brk_p, b});
        else m_ovf_d = 1'b1;
        ext_p = 1'b0;
        brk_p = 1'b0;
      end
    end
  endtask

  task automatic send_frame(input logic [7:0] b, input bit bs, input bit bp, input bit bst);
    send_bits(mk_frame(b, bs, bp, bst), 11);
    wait_clk(20);
    model_frame(b, !(bs || bp || bst));
  endtask

  task automatic pop_once(input int hold);
    nextdata_n = 1'b0;
    wait_clk(hold);
    nextdata_n = 1'b1;
    wait_clk(2);
    if (q_d.size() > 0) begin q_d.delete(0); m_ovf_d = 1'b0; end
    if (q_r.size() > 0) begin q_r.delete(0); m_ovf_r = 1'b0; end
  endtask

  task automatic check_state(input string tag);
    chk({tag, " dec ready"}, {31'b0, rdy_d}, {31'b0, q_d.size() != 0});
    chk({tag, " dec count"}, {29'b0, cnt_d}, q_d.size());
    chk({tag, " dec overflow"}, {31'b0, ovf_d}, {31'b0, m_ovf_d});
    chk({tag, " dec frame_err"}, obs_err_d, exp_err_d);
    if (q_d.size() > 0) chk({tag, " dec head"}, {22'b0, ext_d, brk_d, data_d}, {22'b0, q_d[0]});
    chk({tag, " raw ready"}, {31'b0, rdy_r}, {31'b0, q_r.size() != 0});
    chk({tag, " raw count"}, {29'b0, cnt_r}, q_r.size());
    chk({tag, " raw overflow"}, {31'b0, ovf_r}, {31'b0, m_ovf_r});
    chk({tag, " raw frame_err"}, obs_err_r, exp_err_r);
    if (q_r.size() > 0) chk({tag, " raw head"}, {22'b0, ext_r, brk_r, data_r}, {22'b0, q_r[0]});
  endtask

  task automatic drain(input string tag);
    while (q_d.size() > 0 || q_r.size() > 0) begin
      check_state({tag, " drain"});
      pop_once(3);
    end
    check_state({tag, " drained"});
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, " dec outs"}, {21'b0, data_d, ext_d, brk_d, rdy_d, ovf_d, fe_d, cnt_d}, 32'd0);
    chk({tag, " raw outs"}, {21'b0, data_r, ext_r, brk_r, rdy_r, ovf_r, fe_r, cnt_r}, 32'd0);
  endtask

  task automatic do_reset();
    clrn = 1'b0;
    ps2_clk = 1'b1;
    ps2_data = 1'b1;
    wait_clk(3);
    check_reset_outputs("reset");
    q_d.delete();
    q_r.delete();
    m_ovf_d = 1'b0;
    m_ovf_r = 1'b0;
    ext_p = 1'b0;
    brk_p = 1'b0;
    clrn = 1'b1;
    wait_clk(6);
  endtask

  initial begin
    logic [7:0] b;
    int r, e;

    // Reset state
    wait_clk(4);
    check_reset_outputs("initial");
    clrn = 1'b1;
    wait_clk(6);
    check_state("post reset");

    // Single make code
    send_frame(8'h1C, 0, 0, 0);
    check_state("make");
    chk("make data", {24'b0, data_d}, 32'h1C);
    pop_once(3);
    check_state("make popped");

    // Break and extended-break sequences
    send_frame(8'hF0, 0, 0, 0);
    send_frame(8'h1C, 0, 0, 0);
    check_state("break");
    chk("break flag", {31'b0, brk_d}, 32'd1);
    drain("break");
    send_frame(8'hE0, 0, 0, 0);
    send_frame(8'hF0, 0, 0, 0);
    send_frame(8'h74, 0, 0, 0);
    check_state("ext break");
    chk("ext break head", {22'b0, ext_d, brk_d, data_d}, {22'b0, 2'b11, 8'h74});
    drain("ext break");

    // Overflow with no pops
    send_frame(8'h15, 0, 0, 0);
    send_frame(8'h1D, 0, 0, 0);
    send_frame(8'h24, 0, 0, 0);
    send_frame(8'h2D, 0, 0, 0);
    send_frame(8'h2C, 0, 0, 0);
    check_state("overflow");
    chk("overflow flag", {31'b0, ovf_d}, 32'd1);
    drain("overflow");

    // Frame errors: bad parity, bad stop, then good
    send_frame(8'h1B, 0, 1, 0);
    send_frame(8'h1B, 0, 0, 1);
    check_state("frame errors");
    send_frame(8'h1B, 0, 0, 0);
    check_state("after errors");
    drain("after errors");

    // Pop edge rule
    send_frame(8'h15, 0, 0, 0);
    send_frame(8'h1D, 0, 0, 0);
    send_frame(8'h24, 0, 0, 0);
    pop_once(100);
    check_state("held pop");
    chk("held pop count", {29'b0, cnt_d}, 32'd2);
    drain("held pop");
    pop_once(3);
    check_state("empty pop");

    // Reset mid-frame
    send_bits(mk_frame(8'h1C, 0, 0, 0), 5);
    do_reset();
    send_frame(8'h1B, 0, 0, 0);
    check_state("mid reset");
    drain("mid reset");

`ifdef PS2_TIMEOUT_EN
    // Watchdog: abort keeps pending E0
    send_frame(8'hE0, 0, 0, 0);
    send_bits(mk_frame(8'h1C, 0, 0, 0), 4);
    wait_clk(TO + 10);
    exp_err_d++;
    exp_err_r++;
    check_state("timeout");
    send_frame(8'h1C, 0, 0, 0);
    check_state("after timeout");
    drain("after timeout");
`endif

    // Randomised traffic
    for (int it = 0; it < 40; it++) begin
      r = $urandom_range(0, 9);
      if (r == 0) b = 8'hE0;
      else if (r == 1) b = 8'hF0;
      else b = 8'($urandom);
      e = $urandom_range(0, 11);
      send_frame(b, e == 0, e == 1, e == 2);
      check_state("rand");
      if ($urandom_range(0, 2) == 0) begin
        pop_once($urandom_range(1, 5));
        check_state("rand pop");
      end
    end
    drain("rand");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
